multdiv_stall_ctrl: RTL and testbench

MULTDIV_STALL_CTRL -- requirements
Module: multdiv_stall_ctrl

---
 rtl/multdiv_stall_ctrl.sv | 112 +++++++++++
 tb/tb_multdiv_stall_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/multdiv_stall_ctrl.sv
// Stall/sequence controller for a multi-cycle multiply/divide unit sitting in
// the execute stage: issues the unit, freezes the front end, and retires into X/M.
module multdiv_stall_ctrl #(
    parameter int MULT_LAT = 32,
    parameter int DIV_LAT  = 32,
    parameter int CNT_W    = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             is_mult,
    input  logic             is_div,
    input  logic             div_zero,
    input  logic             flush,
    output logic             md_start,
    output logic             md_op,
    output logic             stall,
    output logic             xm_bubble,
    output logic             md_done,
    output logic             md_err,
    output logic             md_abort,
    output logic             busy,
    output logic [CNT_W-1:0] count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);

    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic             op_nxt;
    logic             err_pend, err_nxt;
    logic             issue;

    assign issue = (state == S_IDLE) && (is_mult || is_div) && !flush;

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        op_nxt    = md_op;
        err_nxt   = err_pend;
        if (flush) begin
            state_nxt = S_IDLE;
            count_nxt = '0;
            err_nxt   = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (issue) begin
                        op_nxt = !is_mult;
                        if (is_mult) begin
                            state_nxt = S_RUN;
                            count_nxt = MULT_LOAD;
                            err_nxt   = 1'b0;
                        end else if (div_zero) begin
                            // Nothing to compute: retire next cycle with the error flag.
                            state_nxt = S_DONE;
                            count_nxt = '0;
                            err_nxt   = 1'b1;
                        end else begin
                            state_nxt = S_RUN;
                            count_nxt = DIV_LOAD;
                            err_nxt   = 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    if (count == '0) state_nxt = S_DONE;
                    else             count_nxt = count - CNT_W'(1);
                end
                S_DONE: begin
                    state_nxt = S_IDLE;
                    err_nxt   = 1'b0;
                end
                default: begin
                    state_nxt = S_IDLE;
                    count_nxt = '0;
                    err_nxt   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            count    <= '0;
            md_op    <= 1'b0;
            err_pend <= 1'b0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            md_op    <= op_nxt;
            err_pend <= err_nxt;
        end
    end

    // Reset masks every handshake output so a mid-operation reset is silent.
    always_comb begin
        md_start  = !reset && issue;
        stall     = !reset && !flush && (issue || state == S_RUN);
        xm_bubble = !reset && (flush || issue || state == S_RUN);
        md_done   = !reset && !flush && (state == S_DONE);
        md_err    = md_done && err_pend;
        md_abort  = !reset && flush && (state == S_RUN || state == S_DONE);
        busy      = !reset && (state != S_IDLE);
    end

endmodule

// File: tb/tb_multdiv_stall_ctrl.sv
// Directed bench for multdiv_stall_ctrl: cycle-by-cycle vector table plus
// hand-written back-to-back and divide-latency sequences.
module tb_multdiv_stall_ctrl;

    localparam int CNT_W = 6;

    logic             clock = 1'b0;
    logic             reset, is_mult, is_div, div_zero, flush;
    logic             md_start, md_op, stall, xm_bubble, md_done, md_err, md_abort, busy;
    logic [CNT_W-1:0] count;

    int total = 0;
    int bad   = 0;

    multdiv_stall_ctrl #(.MULT_LAT(4), .DIV_LAT(6), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .is_mult(is_mult), .is_div(is_div),
        .div_zero(div_zero), .flush(flush), .md_start(md_start), .md_op(md_op),
        .stall(stall), .xm_bubble(xm_bubble), .md_done(md_done), .md_err(md_err),
        .md_abort(md_abort), .busy(busy), .count(count)
    );

    always #5 clock = ~clock;

    // in  = {reset, is_mult, is_div, div_zero, flush}
    // exp = {stall, xm_bubble, md_start, md_done, md_err, md_abort, busy, md_op}
    typedef struct {
        logic [4:0]       in;
        logic [7:0]       exp;
        logic [CNT_W-1:0] cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic row(input logic [4:0] in, input logic [7:0] exp, input int cnt);
        vec_t v;
        v.in  = in;
        v.exp = exp;
        v.cnt = CNT_W'(cnt);
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] in);
        {reset, is_mult, is_div, div_zero, flush} = in;
    endtask

    function automatic logic [7:0] outs();
        return {stall, xm_bubble, md_start, md_done, md_err, md_abort, busy, md_op};
    endfunction

    int done_cyc[$];
    int start_cyc[$];
    int found;

    initial begin
        drive(5'b10000);
        repeat (2) @(posedge clock);

        // reset held with a request present: outputs forced low
        row(5'b11000, 8'b0000_0000, 0);
        // multiply, is_mult held through DONE (ignored there)
        row(5'b01000, 8'b1110_0000, 0);
        row(5'b01000, 8'b1100_0010, 3);
        row(5'b01000, 8'b1100_0010, 2);
        row(5'b01000, 8'b1100_0010, 1);
        row(5'b01000, 8'b1100_0010, 0);
        row(5'b01000, 8'b0001_0010, 0);
        row(5'b00000, 8'b0000_0000, 0);
        // divide by zero
        row(5'b00110, 8'b1110_0000, 0);
        row(5'b00100, 8'b0001_1011, 0);
        row(5'b00000, 8'b0000_0001, 0);
        // divide flushed in cycle 3
        row(5'b00100, 8'b1110_0001, 0);
        row(5'b00100, 8'b1100_0011, 5);
        row(5'b00100, 8'b1100_0011, 4);
        row(5'b00101, 8'b0100_0111, 3);
        row(5'b00000, 8'b0000_0001, 0);
        // flush in IDLE suppresses issue, no abort
        row(5'b01001, 8'b0100_0001, 0);
        row(5'b00000, 8'b0000_0001, 0);
        // flush while in DONE kills md_done/md_err
        row(5'b00110, 8'b1110_0001, 0);
        row(5'b00001, 8'b0100_0111, 0);
        row(5'b00000, 8'b0000_0001, 0);
        // both requests: multiply wins, div_zero ignored
        row(5'b01110, 8'b1110_0001, 0);
        row(5'b01110, 8'b1100_0010, 3);
        row(5'b01110, 8'b1100_0010, 2);
        row(5'b01110, 8'b1100_0010, 1);
        row(5'b01110, 8'b1100_0010, 0);
        row(5'b01110, 8'b0001_0010, 0);
        row(5'b00000, 8'b0000_0000, 0);
        // reset in cycle 2 of a multiply (also overrides flush)
        row(5'b01000, 8'b1110_0000, 0);
        row(5'b01000, 8'b1100_0010, 3);
        row(5'b11001, 8'b0000_0000, 2);
        row(5'b00000, 8'b0000_0000, 0);
        row(5'b00000, 8'b0000_0000, 0);

        foreach (vecs[i]) begin
            @(posedge clock); #1;
            drive(vecs[i].in);
            @(negedge clock);
            chk("outs", i, 32'(outs()), 32'(vecs[i].exp));
            chk("count", i, 32'(count), 32'(vecs[i].cnt));
        end

        // back-to-back multiplies: is_mult held high, dropped after second retire
        for (int c = 0; c < 13; c++) begin
            @(posedge clock); #1;
            drive((c < 12) ? 5'b01000 : 5'b00000);
            @(negedge clock);
            if (md_start) start_cyc.push_back(c);
            if (md_done)  done_cyc.push_back(c);
        end
        chk("b2b_starts", 0, 32'(start_cyc.size()), 32'd2);
        chk("b2b_dones", 0, 32'(done_cyc.size()), 32'd2);
        if (start_cyc.size() == 2) begin
            chk("b2b_start", 0, 32'(start_cyc[0]), 32'd0);
            chk("b2b_start", 1, 32'(start_cyc[1]), 32'd6);
        end
        if (done_cyc.size() == 2) begin
            chk("b2b_done", 0, 32'(done_cyc[0]), 32'd5);
            chk("b2b_done", 1, 32'(done_cyc[1]), 32'd11);
        end

        // ordinary divide: retire at DIV_LAT+1, no error, op=1
        found = -1;
        for (int c = 0; c < 20 && found < 0; c++) begin
            @(posedge clock); #1;
            drive(5'b00100);
            @(negedge clock);
            if (md_done) begin
                found = c;
                chk("div_err", 0, 32'(md_err), 32'd0);
                chk("div_op", 0, 32'(md_op), 32'd1);
            end
        end
        chk("div_done_cyc", 0, found, 32'd7);
        @(posedge clock); #1;
        drive(5'b00000);
        @(negedge clock);
        chk("div_idle_busy", 0, 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
